// File: rtl/scan_scheduler.sv
// scan_scheduler: walks one laser scan beam by beam, filters invalid ranges and
// hands each valid beam to the bresenham ray tracer, one at a time.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   scan_start, abort     scan control (scan_start only honoured when idle)
//   num_beams             beam count, latched on accept
//   sensor_x, sensor_y    scan pose, latched on accept
//   beam_addr             scan buffer read address
//   beam_magnitude/angle  scan buffer read data, one cycle after beam_addr
//   bres_start            one-cycle launch pulse to bresenham
//   bres_magnitude/angle  beam under trace, stable from launch to beam end
//   bres_sensor_x/y       latched scan pose
//   bres_busy             bresenham busy
//   busy, done            scan in progress / one-cycle scan-end pulse
//   beams_traced/skipped  per-scan counters
//   timeout_err           sticky: bresenham missed a start acknowledge
module scan_scheduler #(
  parameter int unsigned BEAM_AW        = 9,
  parameter logic [31:0] MAX_RANGE_BITS = 32'h41000000,
  parameter int unsigned ACK_TIMEOUT    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               scan_start,
  input  logic               abort,
  input  logic [BEAM_AW:0]   num_beams,
  input  logic [31:0]        sensor_x,
  input  logic [31:0]        sensor_y,
  output logic [BEAM_AW-1:0] beam_addr,
  input  logic [31:0]        beam_magnitude,
  input  logic [31:0]        beam_angle,
  output logic               bres_start,
  output logic [31:0]        bres_magnitude,
  output logic [31:0]        bres_angle,
  output logic [31:0]        bres_sensor_x,
  output logic [31:0]        bres_sensor_y,
  input  logic               bres_busy,
  output logic               busy,
  output logic               done,
  output logic [BEAM_AW:0]   beams_traced,
  output logic [BEAM_AW:0]   beams_skipped,
  output logic               timeout_err
);

  localparam int unsigned CNT_W = BEAM_AW + 1;
  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, CHECK, LAUNCH, WAIT_ACK, WAIT_DONE, NEXT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  traced_q, traced_d;
  logic [CNT_W-1:0]  skipped_q, skipped_d;
  logic [ACK_W-1:0]  ack_q, ack_d;
  logic              abort_q, abort_d;
  logic              terr_q, terr_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       mag_q, mag_d, ang_q, ang_d, sx_q, sx_d, sy_q, sy_d;
  logic              mag_invalid;

  // Negative, inf/NaN, zero, or beyond the range limit (positive floats order as unsigned ints)
  assign mag_invalid = beam_magnitude[31]
                     | (beam_magnitude[30:23] == 8'hFF)
                     | (beam_magnitude[30:0] == 31'd0)
                     | (beam_magnitude[30:0] > MAX_RANGE_BITS[30:0]);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    traced_d  = traced_q;
    skipped_d = skipped_q;
    ack_d     = ack_q;
    terr_d    = terr_q;
    mag_d     = mag_q;
    ang_d     = ang_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    abort_d   = (state_q == IDLE) ? 1'b0 : (abort_q | abort);

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          num_d     = num_beams;
          sx_d      = sensor_x;
          sy_d      = sensor_y;
          idx_d     = '0;
          traced_d  = '0;
          skipped_d = '0;
          terr_d    = 1'b0;
          state_d   = (num_beams == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        if (mag_invalid) begin
          skipped_d = skipped_q + CNT_W'(1);
          state_d   = NEXT;
        end else begin
          mag_d   = beam_magnitude;
          ang_d   = beam_angle;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        ack_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bres_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          terr_d    = 1'b1;
          skipped_d = skipped_q + CNT_W'(1);
          state_d   = NEXT;
        end else begin
          ack_d = ack_q + ACK_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bres_busy) begin
          traced_d = traced_q + CNT_W'(1);
          state_d  = NEXT;
        end
      end
      NEXT: begin
        idx_d   = idx_q + CNT_W'(1);
        // An abort arriving on this very cycle still stops the scan here
        state_d = (abort_q || abort || (idx_d == num_q)) ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    start_d = (state_d == LAUNCH);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      traced_q  <= '0;
      skipped_q <= '0;
      ack_q     <= '0;
      abort_q   <= 1'b0;
      terr_q    <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mag_q     <= '0;
      ang_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      traced_q  <= traced_d;
      skipped_q <= skipped_d;
      ack_q     <= ack_d;
      abort_q   <= abort_d;
      terr_q    <= terr_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mag_q     <= mag_d;
      ang_q     <= ang_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
    end
  end

  // The index register drives the RAM address directly; num_beams = 2^BEAM_AW never wraps it
  assign beam_addr      = idx_q[BEAM_AW-1:0];
  assign bres_start     = start_q;
  assign bres_magnitude = mag_q;
  assign bres_angle     = ang_q;
  assign bres_sensor_x  = sx_q;
  assign bres_sensor_y  = sy_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign beams_traced   = traced_q;
  assign beams_skipped  = skipped_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Scoreboard bench for scan_scheduler: stimulus computes expected launches and
// scan results from the float range rules and pushes them; a negedge monitor
// pops and compares whenever the DUT pulses bres_start or done.
module tb_scan_scheduler;

  localparam int unsigned BEAM_AW = 9;
  localparam int unsigned NB      = 1 << BEAM_AW;
  localparam int unsigned ACK_TO  = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               scan_start = 1'b0;
  logic               abort = 1'b0;
  logic [BEAM_AW:0]   num_beams = '0;
  logic [31:0]        sensor_x = '0, sensor_y = '0;
  logic [BEAM_AW-1:0] beam_addr;
  logic [31:0]        beam_magnitude = '0, beam_angle = '0;
  logic               bres_start;
  logic [31:0]        bres_magnitude, bres_angle, bres_sensor_x, bres_sensor_y;
  logic               bres_busy = 1'b0;
  logic               busy, done;
  logic [BEAM_AW:0]   beams_traced, beams_skipped;
  logic               timeout_err;

  always #5 clock = ~clock;

  scan_scheduler #(.BEAM_AW(BEAM_AW), .MAX_RANGE_BITS(32'h41000000), .ACK_TIMEOUT(ACK_TO)) dut (
    .clock(clock), .reset(reset), .scan_start(scan_start), .abort(abort),
    .num_beams(num_beams), .sensor_x(sensor_x), .sensor_y(sensor_y),
    .beam_addr(beam_addr), .beam_magnitude(beam_magnitude), .beam_angle(beam_angle),
    .bres_start(bres_start), .bres_magnitude(bres_magnitude), .bres_angle(bres_angle),
    .bres_sensor_x(bres_sensor_x), .bres_sensor_y(bres_sensor_y), .bres_busy(bres_busy),
    .busy(busy), .done(done), .beams_traced(beams_traced), .beams_skipped(beams_skipped),
    .timeout_err(timeout_err)
  );

  // Scan buffer RAM with one-cycle read latency
  logic [31:0] mem_mag [NB];
  logic [31:0] mem_ang [NB];
  int          tlen    [NB];

  always @(posedge clock) begin
    beam_magnitude <= mem_mag[beam_addr];
    beam_angle     <= mem_ang[beam_addr];
  end

  // Bresenham model: busy from the cycle after start for tlen[addr] cycles, or never
  bit no_ack = 1'b0;
  int remaining = 0;
  always @(posedge clock) begin
    if (reset) begin
      bres_busy <= 1'b0;
      remaining <= 0;
    end else if (bres_start && !no_ack) begin
      bres_busy <= 1'b1;
      remaining <= tlen[beam_addr] - 1;
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
    end else begin
      bres_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [BEAM_AW-1:0] addr;
    logic [31:0]        mag;
    logic [31:0]        ang;
    logic [31:0]        sx;
    logic [31:0]        sy;
  } launch_t;

  typedef struct {
    int traced;
    int skipped;
    int terr;
    int cycles;
  } res_t;

  launch_t exp_launch[$];
  res_t    exp_res[$];
  int      checks = 0;
  int      errors = 0;
  int      busy_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Single-precision value as a real; specials flagged separately
  function automatic bit range_ok(input logic [31:0] b);
    int  e;
    real m, v;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 255) return 1'b0;
    if (e == 0) v = m * (2.0 ** -149);
    else        v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    if (b[31]) v = -v;
    return (v > 0.0) && (v <= 8.0);
  endfunction

  function automatic logic [31:0] rand_mag();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 32'h41000000;
      1: return 32'h41000001;
      2: return 32'h80000000 | r;
      3: return 32'h00000000;
      4: return {1'b0, 8'hFF, r[22:0]};
      5: return r;
      default: return {1'b0, 8'($urandom_range(100, 130)), r[22:0]};
    endcase
  endfunction

  // Monitor: compare DUT launches and scan completions against the scoreboard
  always @(negedge clock) begin
    launch_t l;
    res_t    r;
    if (reset) begin
      busy_cycles = 0;
    end else begin
      if (busy) busy_cycles++;
      if (bres_start) begin
        if (exp_launch.size() == 0) begin
          chk("unexpected_launch_addr", 32'(beam_addr), 32'hFFFFFFFF);
        end else begin
          l = exp_launch.pop_front();
          chk("launch_addr", 32'(beam_addr), 32'(l.addr));
          chk("launch_mag", bres_magnitude, l.mag);
          chk("launch_ang", bres_angle, l.ang);
          chk("launch_sx", bres_sensor_x, l.sx);
          chk("launch_sy", bres_sensor_y, l.sy);
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          r = exp_res.pop_front();
          chk("done_traced", 32'(beams_traced), 32'(r.traced));
          chk("done_skipped", 32'(beams_skipped), 32'(r.skipped));
          chk("done_timeout_err", 32'(timeout_err), 32'(r.terr));
          chk("done_busy", 32'(busy), 32'(1));
          chk("scan_busy_cycles", 32'(busy_cycles), 32'(r.cycles));
        end
        busy_cycles = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_bres_start"}, 32'(bres_start), 32'(0));
    chk({tag, "_beam_addr"}, 32'(beam_addr), 32'(0));
    chk({tag, "_traced"}, 32'(beams_traced), 32'(0));
    chk({tag, "_skipped"}, 32'(beams_skipped), 32'(0));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
    chk({tag, "_bres_mag"}, bres_magnitude, 32'(0));
    chk({tag, "_bres_sx"}, bres_sensor_x, 32'(0));
  endtask

  // One scan. trig_beam >= 0: once that beam launches, wait 3 cycles then pulse
  // abort (or reset when trig_reset). dup_start: extra scan_start while busy.
  task automatic run_scan(input int n, input bit noack, input int trig_beam,
                          input bit trig_reset, input bit dup_start);
    logic [31:0] sx, sy;
    int processed, traced, skipped, terr, cyc, k;
    launch_t l;
    res_t    r;
    sx = $urandom;
    sy = $urandom;
    processed = n;
    if (trig_beam >= 0 && !trig_reset && trig_beam + 1 < n) processed = trig_beam + 1;
    traced = 0; skipped = 0; terr = 0; cyc = 1;
    for (int i = 0; i < processed; i++) begin
      if (range_ok(mem_mag[i])) begin
        l.addr = BEAM_AW'(i); l.mag = mem_mag[i]; l.ang = mem_ang[i]; l.sx = sx; l.sy = sy;
        exp_launch.push_back(l);
        if (noack) begin
          skipped++; terr = 1; cyc += 4 + ACK_TO;
        end else begin
          traced++; cyc += 5 + tlen[i];
        end
      end else begin
        skipped++; cyc += 3;
      end
    end
    r.traced = traced; r.skipped = skipped; r.terr = terr; r.cycles = cyc;
    exp_res.push_back(r);

    no_ack = noack;
    scan_start = 1'b1;
    num_beams  = (BEAM_AW+1)'(n);
    sensor_x   = sx;
    sensor_y   = sy;
    cycles(1);
    scan_start = 1'b0;
    num_beams  = (BEAM_AW+1)'($urandom);
    sensor_x   = $urandom;
    sensor_y   = $urandom;
    if (dup_start) begin
      cycles(2);
      scan_start = 1'b1;
      num_beams  = (BEAM_AW+1)'(7);
      cycles(1);
      scan_start = 1'b0;
    end

    if (trig_beam >= 0) begin
      k = 0;
      while (!(bres_start && (int'(beam_addr) == trig_beam)) && k < 20000) begin
        cycles(1);
        k++;
      end
      if (k >= 20000) chk("trigger_launch_timeout", 32'(0), 32'(1));
      cycles(3);
      if (trig_reset) begin
        reset = 1'b1;
        exp_launch.delete();
        exp_res.delete();
        cycles(1);
        reset = 1'b0;
        check_zero("post_reset");
        cycles(2);
        check_zero("post_reset_idle");
        return;
      end
      abort = 1'b1;
      cycles(1);
      abort = 1'b0;
    end

    k = 0;
    while (!done && k < 20000) begin
      cycles(1);
      k++;
    end
    if (k >= 20000) chk("done_timeout", 32'(0), 32'(1));
    cycles(2);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      mem_mag[i] = '0;
      mem_ang[i] = '0;
      tlen[i]    = 1;
    end
    cycles(3);
    reset = 1'b0;
    check_zero("reset");

    // Three valid 2.0 beams, bresenham busy 10 cycles each
    for (int i = 0; i < 3; i++) begin
      mem_mag[i] = 32'h40000000; mem_ang[i] = $urandom; tlen[i] = 10;
    end
    run_scan(3, 1'b0, -1, 1'b0, 1'b0);

    // 1.0, 0.0, NaN, 9.0: only beam 0 traced
    mem_mag[0] = 32'h3F800000; mem_mag[1] = 32'h00000000;
    mem_mag[2] = 32'h7FC00000; mem_mag[3] = 32'h41100000;
    for (int i = 0; i < 4; i++) begin
      mem_ang[i] = $urandom; tlen[i] = $urandom_range(1, 6);
    end
    run_scan(4, 1'b0, -1, 1'b0, 1'b0);

    // Empty scan
    run_scan(0, 1'b0, -1, 1'b0, 1'b0);

    // Abort during beam 1 of 5
    for (int i = 0; i < 5; i++) begin
      mem_mag[i] = 32'h3FC00000; mem_ang[i] = $urandom; tlen[i] = 10;
    end
    run_scan(5, 1'b0, 1, 1'b0, 1'b0);

    // Bresenham never acknowledges
    run_scan(2, 1'b1, -1, 1'b0, 1'b0);
    chk("timeout_err_sticky_idle", 32'(timeout_err), 32'(1));

    // Reset mid-trace, then a normal scan with a stray second start pulse
    for (int i = 0; i < 3; i++) tlen[i] = 10;
    run_scan(3, 1'b0, 1, 1'b1, 1'b0);
    run_scan(3, 1'b0, -1, 1'b0, 1'b1);

    // Randomised scans, including the full 2^BEAM_AW beam count
    for (int s = 0; s < 8; s++) begin
      int n;
      n = (s == 7) ? int'(NB) : int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) begin
        mem_mag[i] = rand_mag();
        mem_ang[i] = $urandom;
        tlen[i]    = $urandom_range(1, 4);
      end
      run_scan(n, 1'b0, -1, 1'b0, 1'b0);
    end

    chk("launch_queue_drained", 32'(exp_launch.size()), 32'(0));
    chk("result_queue_drained", 32'(exp_res.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
